// File: rtl/decode_pipe_reg_if.sv
// Decode-to-execute stage bus: upstream entry, writeback bypass, downstream entry and stall counter.
interface decode_pipe_reg_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned CNT_W   = 8
);
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_OPS*DATA_W-1:0]   in_ops;
  logic [NUM_OPS*ADDR_W-1:0]   in_srcs;
  logic                        wb_en;
  logic [ADDR_W-1:0]           wb_addr;
  logic [DATA_W-1:0]           wb_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_OPS*DATA_W-1:0]   out_ops;
  logic [NUM_OPS*ADDR_W-1:0]   out_srcs;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output flush, in_valid, in_ops, in_srcs, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_ops, out_srcs, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_ops, in_srcs, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_ops, out_srcs, stall_cnt
  );
endinterface

// File: rtl/decode_pipe_reg.sv
// Decode-to-execute pipeline register with valid/ready stall, flush, writeback bypass
// into captured and held operands, and a saturating stall counter.
module decode_pipe_reg #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_OPS  = 2,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input logic              clk,
  input logic              rst,
  decode_pipe_reg_if.slave bus
);

  logic                      r_valid;
  logic [NUM_OPS*DATA_W-1:0] r_ops;
  logic [NUM_OPS*ADDR_W-1:0] r_srcs;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_ready;
  logic                      w_load;
  logic                      w_stall;
  logic [NUM_OPS*DATA_W-1:0] w_cap_ops;
  logic [NUM_OPS*DATA_W-1:0] w_hold_ops;

  assign w_ready = !r_valid || bus.out_ready;
  assign w_load  = bus.in_valid && w_ready && !bus.flush;
  assign w_stall = r_valid && !bus.out_ready && !bus.flush;

  // Capture priority: hardwired zero, then writeback forwarding, then register-file value.
  always_comb begin
    w_cap_ops  = '0;
    w_hold_ops = r_ops;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (ZERO_REG && bus.in_srcs[i*ADDR_W +: ADDR_W] == '0)
        w_cap_ops[i*DATA_W +: DATA_W] = '0;
      else if (bus.wb_en && bus.wb_addr == bus.in_srcs[i*ADDR_W +: ADDR_W])
        w_cap_ops[i*DATA_W +: DATA_W] = bus.wb_data;
      else
        w_cap_ops[i*DATA_W +: DATA_W] = bus.in_ops[i*DATA_W +: DATA_W];

      if (bus.wb_en && bus.wb_addr == r_srcs[i*ADDR_W +: ADDR_W] &&
          !(ZERO_REG && r_srcs[i*ADDR_W +: ADDR_W] == '0))
        w_hold_ops[i*DATA_W +: DATA_W] = bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ops   <= '0;
      r_srcs  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ops   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ops   <= w_cap_ops;
      r_srcs  <= bus.in_srcs;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      r_ops   <= w_hold_ops;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_stall && r_cnt != '1)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_ops   = r_ops;
  assign bus.out_srcs  = r_srcs;
  assign bus.stall_cnt = r_cnt;

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Randomised and directed bench for decode_pipe_reg: driver updates a reference model and
// queues expected transfers; a negedge monitor pops and compares on every accepted output.
module tb_decode_pipe_reg;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_OPS = 2;
  localparam int unsigned ADDR_W  = 3;
  localparam bit          ZERO_R  = 1'b1;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned OW      = NUM_OPS * DATA_W;
  localparam int unsigned SW      = NUM_OPS * ADDR_W;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_pipe_reg_if #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  decode_pipe_reg #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_R), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [OW-1:0] ops;
    logic [SW-1:0] srcs;
  } xfer_t;

  xfer_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the held entry as plain arrays plus an integer stall count.
  bit                m_valid;
  logic [DATA_W-1:0] m_ops [NUM_OPS];
  logic [ADDR_W-1:0] m_srcs[NUM_OPS];
  int unsigned       m_cnt;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [OW-1:0] pack_ops();
    logic [OW-1:0] v;
    for (int i = 0; i < int'(NUM_OPS); i++) v[i*DATA_W +: DATA_W] = m_ops[i];
    return v;
  endfunction

  function automatic logic [SW-1:0] pack_srcs();
    logic [SW-1:0] v;
    for (int i = 0; i < int'(NUM_OPS); i++) v[i*ADDR_W +: ADDR_W] = m_srcs[i];
    return v;
  endfunction

  task automatic drive_idle();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_ops = '0; bus.in_srcs = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    m_valid = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < int'(NUM_OPS); i++) begin m_ops[i] = '0; m_srcs[i] = '0; end
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive, check live outputs, queue the expected transfer, advance the model.
  task automatic step(input logic f, input logic iv, input logic [OW-1:0] ops,
                      input logic [SW-1:0] srcs, input logic we,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic ordy);
    bit rdy;
    logic [ADDR_W-1:0] s;
    xfer_t e;
    bus.flush = f; bus.in_valid = iv; bus.in_ops = ops; bus.in_srcs = srcs;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd; bus.out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    if (m_valid && ordy && !f) begin
      e.ops  = pack_ops();
      e.srcs = pack_srcs();
      sbq.push_back(e);
    end
    @(posedge clk);
    if (!f && m_valid && !ordy && m_cnt < CNT_MAX) m_cnt++;
    if (f) begin
      m_valid = 1'b0;
      for (int i = 0; i < int'(NUM_OPS); i++) m_ops[i] = '0;
    end else if (iv && rdy) begin
      m_valid = 1'b1;
      for (int i = 0; i < int'(NUM_OPS); i++) begin
        s = srcs[i*ADDR_W +: ADDR_W];
        m_srcs[i] = s;
        if (ZERO_R && s == 0)       m_ops[i] = '0;
        else if (we && wa == s)     m_ops[i] = wd;
        else                        m_ops[i] = ops[i*DATA_W +: DATA_W];
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end else if (m_valid) begin
      for (int i = 0; i < int'(NUM_OPS); i++)
        if (we && wa == m_srcs[i] && !(ZERO_R && m_srcs[i] == 0)) m_ops[i] = wd;
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ordy);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.flush === 1'b0) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_xfer: got ops 0x%0h srcs 0x%0h, expected no transfer", bus.out_ops, bus.out_srcs);
      end else begin
        xfer_t e;
        e = sbq.pop_front();
        check("xfer_ops", 64'(bus.out_ops), 64'(e.ops));
        check("xfer_srcs", 64'(bus.out_srcs), 64'(e.srcs));
      end
    end
  end

  initial begin
    drive_idle();
    do_reset();

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_ops", 64'(bus.out_ops), 64'd0);
    check("rst_out_srcs", 64'(bus.out_srcs), 64'd0);
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);

    // Back-to-back stream of four entries
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b1, {8'h34 + 8'(k), 8'h12 + 8'(k)}, {3'd2, 3'd1}, 1'b0, '0, '0, 1'b1);
    check("stream_valid", 64'(bus.out_valid), 64'd1);
    check("stream_ops", 64'(bus.out_ops), 64'h3715);
    idle(1'b1);

    // Capture bypass with hardwired zero on channel 1
    step(1'b0, 1'b1, {8'h55, 8'hAA}, {3'd0, 3'd3}, 1'b1, 3'd3, 8'h7E, 1'b0);
    check("cap_bypass_ops", 64'(bus.out_ops), 64'h007E);
    idle(1'b1);

    // Hold bypass across duplicated source index
    do_reset();
    step(1'b0, 1'b1, {8'h11, 8'h22}, {3'd4, 3'd4}, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b1, 16'hBEEF, {3'd5, 3'd6}, k == 1, 3'd4, 8'h99, 1'b0);
    check("hold_ops", 64'(bus.out_ops), 64'h9999);
    check("hold_srcs", 64'(bus.out_srcs), 64'(6'o44));
    check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    check("hold_stall_cnt", 64'(bus.stall_cnt), 64'd5);
    idle(1'b1);

    // Flush while holding, with an incoming entry offered
    step(1'b0, 1'b1, {8'hC1, 8'hC0}, {3'd2, 3'd1}, 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, {8'hD1, 8'hD0}, {3'd6, 3'd5}, 1'b0, '0, '0, 1'b0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ops", 64'(bus.out_ops), 64'd0);
    check("flush_srcs_kept", 64'(bus.out_srcs), 64'(6'o21));
    step(1'b0, 1'b1, {8'hE1, 8'hE0}, {3'd7, 3'd3}, 1'b0, '0, '0, 1'b1);
    idle(1'b1);

    // Counter saturation, then reset mid-stall
    do_reset();
    step(1'b0, 1'b1, {8'h01, 8'h02}, {3'd1, 3'd2}, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 10; k++) idle(1'b0);
    check("sat_stall_cnt", 64'(bus.stall_cnt), 64'(CNT_MAX));
    do_reset();
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_ops", 64'(bus.out_ops), 64'd0);
    check("midrst_srcs", 64'(bus.out_srcs), 64'd0);
    check("midrst_cnt", 64'(bus.stall_cnt), 64'd0);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      logic [SW-1:0] srcs;
      logic [ADDR_W-1:0] wa;
      if ($urandom_range(0, 149) == 0) do_reset();
      srcs = SW'($urandom);
      wa = ($urandom_range(0, 1) == 1) ? srcs[ADDR_W-1:0] : ADDR_W'($urandom);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, OW'($urandom), srcs,
           $urandom_range(0, 1) == 1, wa, DATA_W'($urandom), $urandom_range(0, 2) != 0);
    end
    idle(1'b1);
    idle(1'b1);
    check("sbq_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_pipe_reg.md
Name: decode_pipe_reg

Overview:
- Parametrised decode-to-execute pipeline register carrying NUM_OPS register-read operands, each with its source register index.
- Adds a valid/ready handshake (stall), flush, and writeback bypass into captured and held operands.
- Adds a saturating stall counter for performance monitoring.
- Sits between the register-file read stage and the ALU stage.

Parameters:
DATA_W, 8, operand width in bits
NUM_OPS, 2, number of operand channels
ADDR_W, 3, register index width
ZERO_REG, 1, when 1 register index 0 is hardwired zero: never bypassed, captured as 0
CNT_W, 8, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  discard the current and incoming entry
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_ops  input  NUM_OPS*DATA_W  operand values; channel i is bits [i*DATA_W +: DATA_W]
in_srcs  input  NUM_OPS*ADDR_W  source register index per channel
wb_en  input  1  writeback occurring this cycle
wb_addr  input  ADDR_W  writeback destination index
wb_data  input  DATA_W  writeback value
out_valid  output  1  held entry valid
out_ready  input  1  downstream accepts the held entry
out_ops  output  NUM_OPS*DATA_W  held operand values
out_srcs  output  NUM_OPS*ADDR_W  held source indices
stall_cnt  output  CNT_W  count of stall cycles, saturating

Behaviour:
- Reset: rst=1 at a rising edge sets out_valid=0, out_ops=0, out_srcs=0, stall_cnt=0.
  - Reset overrides flush, load and bypass.
  - Reset mid-stall drops the held entry.
- in_ready = !out_valid | out_ready. It is combinational and does not depend on in_valid.
- Load: load = in_valid & in_ready & !flush.
  - At the edge, out_valid<=1, out_srcs<=in_srcs.
  - out_ops channel i <= capture value i. Latency is one cycle, so the output is visible the cycle after the load.
- Capture value i, in priority order:
  - 0 if ZERO_REG=1 and in_srcs[i]==0;
  - else wb_data if wb_en and wb_addr==in_srcs[i];
  - else in_ops[i].
- Drain: out_valid & out_ready & !load sets out_valid<=0. Data registers keep their value.
- Back-to-back: drain and load in the same cycle means out_valid stays 1 and the new entry replaces the old one, giving one entry per cycle throughput.
- Hold (out_valid & !out_ready):
  - Entry is retained.
  - For each channel, if wb_en & wb_addr==out_srcs[i] and not (ZERO_REG & out_srcs[i]==0), then out_ops[i]<=wb_data.
  - All matching channels update in the same cycle. Multiple channels with the same index all update.
- Flush:
  - At the edge, out_valid<=0 and out_ops<=0. out_srcs is left unchanged.
  - Flush has priority over load, drain and hold-bypass.
  - in_ready is still computed normally, but no entry is captured during flush.
- stall_cnt increments by 1 on every cycle with out_valid & !out_ready & !flush. It saturates at 2^CNT_W-1 and clears only on rst.
- Width rules:
  - All comparisons are full ADDR_W equality.
  - No arithmetic on operands.
  - stall_cnt is unsigned with no wrap.
- Downstream sees out_* only when out_valid=1. Values while out_valid=0 are don't-care except after reset or flush (zero).

Test Plan:
- Reset then idle -> out_valid=0, out_ops=0, out_srcs=0, stall_cnt=0, in_ready=1.
- Load with in_ops={0x12,0x34}, srcs={1,2}, out_ready=1, stream 4 entries on consecutive cycles -> each appears one cycle later, out_valid stays 1, no bubbles, stall_cnt=0.
- Capture bypass: load srcs={3,0} with ops={0xAA,0x55}, wb_en=1, wb_addr=3, wb_data=0x7E, ZERO_REG=1 -> out_ops={0x7E,0x00}.
- Hold bypass: hold entry srcs={4,4}, out_ready=0 for 5 cycles, wb to 4 with 0x99 in cycle 2 -> both ops become 0x99, entry is kept, in_ready=0, stall_cnt=5.
- Flush during hold with in_valid=1, then release -> out_valid=0 and out_ops=0 next cycle, the incoming entry is dropped, and the next in_valid loads normally.
- CNT_W=3, out_ready=0 for 10 cycles -> stall_cnt saturates at 7. Asserting rst mid-stall -> everything is zero the next cycle.
